mda_safety_interlock: RTL and testbench
=======================================

# mda_safety_interlock

Parametrised, stateful successor to the team's global GPIO disable. Gates `NUM_IOS` GPIO outputs behind `NUM_IN` shutdown sources. Adds four things:
- per-source enable masking;
- a glitch filter on each source;
- a latching or auto-recovering trip mode;
- a timed re-arm holdoff, with cause and event reporting.

It sits between the GPIO driver logic and the pins. While the block is not ARMED, the pins are forced to a safe pattern.

## Interface
Parameters:
- `NUM_IN`, 2, number of shutdown sources (≥1)
- `NUM_IOS`, 2, number of gated GPIO bits (≥1)
- `FILTER_CYCLES`, 4, consecutive high cycles before a source counts as active (≥1)
- `REARM_CYCLES`, 16, clean cycles spent in REARM before returning to ARMED (≥1)

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `shutdown`  in  NUM_IN  raw shutdown requests, active-high, already synchronous to clk
- `shutdown_mask`  in  NUM_IN  1 = source enabled, 0 = source ignored
- `latch_en`  in  1  1 = trip is sticky until `clear`; 0 = trip auto-recovers
- `clear`  in  1  single-cycle request to leave TRIPPED and to clear `trip_cause`
- `gpio_in`  in  NUM_IOS  normal-operation GPIO values
- `gpio_out_default`  in  NUM_IOS  safe GPIO pattern
- `gpio_out`  out  NUM_IOS  registered GPIO output
- `armed`  out  1  state == ARMED
- `tripped`  out  1  state == TRIPPED
- `trip_cause`  out  NUM_IN  sticky record of sources that have been active
- `trip_count`  out  8  saturating count of ARMED→TRIPPED and REARM→TRIPPED transitions

## Operation
Filter:
- Each source has a counter of width `$clog2(FILTER_CYCLES+1)`.
- When `shutdown[i] & shutdown_mask[i]` is high, the counter increments, saturating at FILTER_CYCLES. Otherwise it clears to 0 in the same edge.
- `active[i]` = (counter == FILTER_CYCLES). It is a registered value.
- `trip` = |active.

States: REARM, ARMED, TRIPPED.
- **Reset** (`reset_n` = 0 at an edge):
  - state = REARM, rearm counter = 0, all filter counters = 0;
  - `trip_cause` = 0, `trip_count` = 0;
  - `gpio_out` = `gpio_out_default` as sampled at that edge;
  - `armed` = 0, `tripped` = 0.
- **REARM:**
  - `trip` → TRIPPED, and the rearm counter clears.
  - Otherwise the counter increments. When the counter reaches REARM_CYCLES−1, the state goes to ARMED on that edge. REARM therefore lasts exactly REARM_CYCLES cycles.
- **ARMED:** `trip` → TRIPPED.
- **TRIPPED:**
  - If `latch_en` = 1: leave only when `clear` = 1 and `trip` = 0 → REARM. A `clear` while `trip` = 1 is ignored for state purposes.
  - If `latch_en` = 0: `trip` = 0 → REARM. `clear` is not needed.
- **`gpio_out`:**
  - Next state ARMED → `gpio_out` <= `gpio_in`.
  - Any other next state → `gpio_out` <= `gpio_out_default`.
  - `gpio_out` is computed from the next state, so it updates on the same edge as the state.
- **`trip_cause`:**
  - `clear` = 1 → `trip_cause` <= `active`. Still-active sources stay recorded.
  - Otherwise → `trip_cause` <= `trip_cause` | `active`.
  - This applies in every state.
- **`trip_count`:** increments by 1 on each entry into TRIPPED and saturates at 255. Only reset clears it.
- **Mask changes:**
  - Clearing a mask bit zeroes that source's filter counter on the next edge.
  - The already-recorded `trip_cause` bit is retained.
- **`latch_en` change while TRIPPED:** takes effect on the next edge.

## Timing
- **Trip latency:** with `shutdown[i]` high and unmasked from edge 1 onward, `active[i]` is high after edge FILTER_CYCLES. State, `tripped` and `gpio_out` = default change on edge FILTER_CYCLES+1.
- **Filter rejection:** a pulse shorter than FILTER_CYCLES cycles never trips. A single low cycle restarts the filter count.
- **Release latency, non-latching:**
  - `active` falls on the first edge that samples the source low.
  - TRIPPED→REARM happens on the next edge.
  - ARMED, with `gpio_out` = `gpio_in`, follows REARM_CYCLES edges later.
- **Release, latching:** `clear` sampled high with `trip` = 0 → REARM on that edge. ARMED follows REARM_CYCLES edges later.
- **Simultaneous `clear` and new trip:** the trip wins and the state stays TRIPPED.
- **Pass-through latency:** in ARMED, `gpio_out` follows `gpio_in` with 1-cycle latency.
- **Reset mid-trip:** always returns to REARM. Outputs stay at default for at least REARM_CYCLES cycles after `reset_n` rises.

## Test plan
All scenarios use NUM_IN=2, NUM_IOS=4, FILTER_CYCLES=4, REARM_CYCLES=16, `gpio_out_default`=4'b0000, `gpio_in`=4'b1011.
1. **Reset then idle:** release reset, inputs quiet → `gpio_out`=0000 for 16 cycles, then `armed`=1 and `gpio_out`=1011 on the next edge.
2. **Glitch rejection:** `shutdown[0]` high for 3 cycles while ARMED → no trip, `gpio_out` stays 1011, `trip_count`=0.
3. **Latching trip:**
   - Setup: `latch_en`=1; `shutdown[1]` high for 10 cycles.
   - Response: TRIPPED on the 5th edge, `gpio_out`=0000, `trip_cause`=2'b10, `trip_count`=1.
   - After the source drops, the state stays TRIPPED until `clear`. After `clear`: REARM, then ARMED 16 cycles later.
4. **Non-latching:** `latch_en`=0; `shutdown[0]` high for 6 cycles → TRIPPED, then auto REARM one edge after `active` drops, then ARMED with no `clear`. `trip_cause`=2'b01 persists.
5. **Masking and simultaneous events:**
   - `shutdown_mask`=2'b01 with `shutdown[1]` held high → no trip.
   - In TRIPPED, assert `clear` on the same edge as a fresh filtered trip → the state stays TRIPPED.
6. **Saturation and reset:**
   - Force 300 trip/re-arm cycles → `trip_count`=255.
   - Assert `reset_n`=0 mid-trip → state REARM, `trip_count`=0, `trip_cause`=0.

Source files
------------

// File: rtl/mda_safety_interlock.sv
// GPIO safety interlock: filtered, maskable shutdown sources gate the GPIO outputs
// through a REARM/ARMED/TRIPPED state machine with cause and trip-count reporting.
module mda_safety_interlock #(
    parameter int NUM_IN        = 2,
    parameter int NUM_IOS       = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int REARM_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IN-1:0]  shutdown,
    input  logic [NUM_IN-1:0]  shutdown_mask,
    input  logic               latch_en,
    input  logic               clear,
    input  logic [NUM_IOS-1:0] gpio_in,
    input  logic [NUM_IOS-1:0] gpio_out_default,
    output logic [NUM_IOS-1:0] gpio_out,
    output logic               armed,
    output logic               tripped,
    output logic [NUM_IN-1:0]  trip_cause,
    output logic [7:0]         trip_count
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int RW = $clog2(REARM_CYCLES + 1);

    typedef enum logic [1:0] {
        REARM,
        ARMED,
        TRIPPED
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     filt_cnt [NUM_IN];
    logic [NUM_IN-1:0] active;
    logic              trip;
    logic [RW-1:0]     rearm_cnt;

    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            active[i] = (filt_cnt[i] == FW'(FILTER_CYCLES));
        end
    end

    assign trip = |active;

    // Counters saturate at FILTER_CYCLES; any low or masked cycle restarts them.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!reset_n) begin
                filt_cnt[i] <= '0;
            end else if (shutdown[i] && shutdown_mask[i]) begin
                if (!active[i]) begin
                    filt_cnt[i] <= filt_cnt[i] + FW'(1);
                end
            end else begin
                filt_cnt[i] <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REARM: begin
                if (trip) begin
                    state_nxt = TRIPPED;
                end else if (rearm_cnt == RW'(REARM_CYCLES - 1)) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (trip) begin
                    state_nxt = TRIPPED;
                end
            end
            TRIPPED: begin
                if (!trip && (!latch_en || clear)) begin
                    state_nxt = REARM;
                end
            end
            default: state_nxt = REARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= REARM;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter only runs while staying in REARM, so every REARM entry starts from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rearm_cnt <= '0;
        end else if (state == REARM && state_nxt == REARM) begin
            rearm_cnt <= rearm_cnt + RW'(1);
        end else begin
            rearm_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gpio_out   <= gpio_out_default;
            trip_cause <= '0;
            trip_count <= '0;
        end else begin
            gpio_out   <= (state_nxt == ARMED) ? gpio_in : gpio_out_default;
            trip_cause <= clear ? active : (trip_cause | active);
            if (state_nxt == TRIPPED && state != TRIPPED && trip_count != 8'hFF) begin
                trip_count <= trip_count + 8'd1;
            end
        end
    end

    assign armed   = (state == ARMED);
    assign tripped = (state == TRIPPED);

endmodule

// File: tb/tb_mda_safety_interlock.sv
// Vector-table bench for mda_safety_interlock: each record holds stimulus, a cycle
// count and the expected outputs, which go through a scoreboard queue for checking.
module tb_mda_safety_interlock;

    typedef struct packed {
        logic       armed;
        logic       tripped;
        logic [3:0] gpio;
        logic [1:0] cause;
        logic [7:0] count;
    } exp_t;

    typedef struct packed {
        logic       rst_n;
        logic [1:0] sd;
        logic [1:0] mask;
        logic       latch;
        logic       clr;
        int         cyc;
        exp_t       want;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] shutdown;
    logic [1:0] shutdown_mask;
    logic       latch_en;
    logic       clear;
    logic [3:0] gpio_in;
    logic [3:0] gpio_out_default;
    logic [3:0] gpio_out;
    logic       armed;
    logic       tripped;
    logic [1:0] trip_cause;
    logic [7:0] trip_count;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[25];

    always #5 clk = ~clk;

    mda_safety_interlock #(
        .NUM_IN       (2),
        .NUM_IOS      (4),
        .FILTER_CYCLES(4),
        .REARM_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .shutdown        (shutdown),
        .shutdown_mask   (shutdown_mask),
        .latch_en        (latch_en),
        .clear           (clear),
        .gpio_in         (gpio_in),
        .gpio_out_default(gpio_out_default),
        .gpio_out        (gpio_out),
        .armed           (armed),
        .tripped         (tripped),
        .trip_cause      (trip_cause),
        .trip_count      (trip_count)
    );

    function automatic vec_t mk(input logic r, input logic [1:0] sd, input logic [1:0] m,
                                input logic l, input logic c, input int n,
                                input logic a, input logic t, input logic [3:0] g,
                                input logic [1:0] cs, input logic [7:0] cnt);
        vec_t v;
        v.rst_n = r;  v.sd = sd;  v.mask = m;  v.latch = l;  v.clr = c;  v.cyc = n;
        v.want.armed = a;  v.want.tripped = t;  v.want.gpio = g;
        v.want.cause = cs;  v.want.count = cnt;
        return v;
    endfunction

    // Drive on the falling edge, run v.cyc rising edges, sample on the following falling edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t got;
        exp_t want;
        reset_n       = v.rst_n;
        shutdown      = v.sd;
        shutdown_mask = v.mask;
        latch_en      = v.latch;
        clear         = v.clr;
        sb.push_back(v.want);
        repeat (v.cyc) @(negedge clk);
        got  = {armed, tripped, gpio_out, trip_cause, trip_count};
        want = sb.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got armed=%b tripped=%b gpio=%b cause=%b count=%0d, want armed=%b tripped=%b gpio=%b cause=%b count=%0d",
                     tag, got.armed, got.tripped, got.gpio, got.cause, got.count,
                     want.armed, want.tripped, want.gpio, want.cause, want.count);
        end
    endtask

    initial begin
        int cnt_model;
        gpio_in          = 4'b1011;
        gpio_out_default = 4'b0000;

        //              rst sd     mask   lat  clr  cyc  arm  trp  gpio     cause  count
        vecs[0]  = mk(1'b0, 2'b00, 2'b11, 1'b0, 1'b0,  2, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd0);
        vecs[1]  = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 15, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd0);
        vecs[2]  = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd0);
        vecs[3]  = mk(1'b1, 2'b01, 2'b11, 1'b0, 1'b0,  3, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd0);
        vecs[4]  = mk(1'b1, 2'b00, 2'b11, 1'b1, 1'b0,  1, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd0);
        vecs[5]  = mk(1'b1, 2'b10, 2'b11, 1'b1, 1'b0,  4, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd0);
        vecs[6]  = mk(1'b1, 2'b10, 2'b11, 1'b1, 1'b0,  1, 1'b0, 1'b1, 4'b0000, 2'b10, 8'd1);
        vecs[7]  = mk(1'b1, 2'b10, 2'b11, 1'b1, 1'b0,  5, 1'b0, 1'b1, 4'b0000, 2'b10, 8'd1);
        vecs[8]  = mk(1'b1, 2'b00, 2'b11, 1'b1, 1'b0,  3, 1'b0, 1'b1, 4'b0000, 2'b10, 8'd1);
        vecs[9]  = mk(1'b1, 2'b00, 2'b11, 1'b1, 1'b1,  1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd1);
        vecs[10] = mk(1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 15, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd1);
        vecs[11] = mk(1'b1, 2'b00, 2'b11, 1'b1, 1'b0,  1, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd1);
        vecs[12] = mk(1'b1, 2'b01, 2'b11, 1'b0, 1'b0,  6, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd2);
        vecs[13] = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd2);
        vecs[14] = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'b0000, 2'b01, 8'd2);
        vecs[15] = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 15, 1'b0, 1'b0, 4'b0000, 2'b01, 8'd2);
        vecs[16] = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b1, 1'b0, 4'b1011, 2'b01, 8'd2);
        vecs[17] = mk(1'b1, 2'b10, 2'b01, 1'b0, 1'b0,  8, 1'b1, 1'b0, 4'b1011, 2'b01, 8'd2);
        vecs[18] = mk(1'b1, 2'b11, 2'b01, 1'b1, 1'b0,  5, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd3);
        vecs[19] = mk(1'b1, 2'b00, 2'b01, 1'b1, 1'b0,  1, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd3);
        vecs[20] = mk(1'b1, 2'b01, 2'b01, 1'b1, 1'b0,  4, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd3);
        vecs[21] = mk(1'b1, 2'b01, 2'b01, 1'b1, 1'b1,  1, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd3);
        vecs[22] = mk(1'b1, 2'b00, 2'b01, 1'b1, 1'b0,  1, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd3);
        vecs[23] = mk(1'b1, 2'b00, 2'b01, 1'b1, 1'b1,  1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd3);
        vecs[24] = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 16, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd3);

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Repeated non-latching trip/re-arm cycles drive trip_count into saturation.
        cnt_model = 3;
        for (int k = 0; k < 300; k++) begin
            cnt_model = (cnt_model == 255) ? 255 : cnt_model + 1;
            apply(mk(1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 5, 1'b0, 1'b1, 4'b0000, 2'b01, 8'(cnt_model)),
                  $sformatf("sat_trip%0d", k));
            apply(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 4'b0000, 2'b01, 8'(cnt_model)),
                  $sformatf("sat_rearm%0d", k));
        end

        // Reset in the middle of a trip, then a clean re-arm and pass-through update.
        apply(mk(1'b1, 2'b01, 2'b11, 1'b0, 1'b0,  5, 1'b0, 1'b1, 4'b0000, 2'b01, 8'd255), "final_trip");
        apply(mk(1'b0, 2'b01, 2'b11, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd0),   "reset_mid_trip");
        apply(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 15, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd0),   "post_reset_rearm");
        apply(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b1, 1'b0, 4'b1011, 2'b00, 8'd0),   "post_reset_armed");
        gpio_in = 4'b0110;
        apply(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0,  1, 1'b1, 1'b0, 4'b0110, 2'b00, 8'd0),   "pass_through");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
